// File: rtl/lsu_mem_handshake_if.sv
// Data-memory port bundle between the MEM-stage LSU controller (master) and memory (slave).
interface lsu_mem_handshake_if;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_bmask;
    logic        i_mem_gnt;
    logic        i_mem_rvalid;
    logic [31:0] i_mem_rdata;

    modport master (
        output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_bmask,
        input  i_mem_gnt, i_mem_rvalid, i_mem_rdata
    );

    modport slave (
        input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_bmask,
        output i_mem_gnt, i_mem_rvalid, i_mem_rdata
    );
endinterface

// File: rtl/lsu_mem_handshake.sv
// MEM-stage load/store controller: request/grant/response sequencing with pipeline stall.
// Optional watchdog abort is enabled by defining LSU_TIMEOUT_EN.
module lsu_mem_handshake #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_lsu_req,
    input  logic                       i_lsu_wren,
    input  logic [31:0]                i_lsu_addr,
    input  logic [31:0]                i_lsu_wdata,
    input  logic [3:0]                 i_lsu_bmask,
    lsu_mem_handshake_if.master        mem,
    output logic                       o_stall_lsu,
    output logic [31:0]                o_lsu_rdata,
    output logic                       o_lsu_done,
    output logic                       o_lsu_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic        wren_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  bmask_q;
    logic [31:0] rdata_q;
    logic        capture_rdata;
    logic        abort;
    logic        timeout;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        capture_rdata = 1'b0;
        abort         = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_lsu_req) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (mem.i_mem_gnt) begin
                    if (wren_q) begin
                        state_d = DONE;
                    end else if (mem.i_mem_rvalid) begin
                        capture_rdata = 1'b1;
                        state_d       = DONE;
                    end else begin
                        state_d = WAIT;
                    end
                end else if (timeout) begin
                    abort   = 1'b1;
                    state_d = DONE;
                end
            end
            WAIT: begin
                if (mem.i_mem_rvalid) begin
                    capture_rdata = 1'b1;
                    state_d       = DONE;
                end else if (timeout) begin
                    abort   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Request fields are latched once in IDLE so the memory port stays stable until grant.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            wren_q  <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            bmask_q <= 4'h0;
            rdata_q <= 32'h0;
        end else begin
            if (state_q == IDLE && i_lsu_req) begin
                wren_q  <= i_lsu_wren;
                addr_q  <= i_lsu_addr;
                wdata_q <= i_lsu_wdata;
                bmask_q <= i_lsu_bmask;
            end
            if (capture_rdata) begin
                rdata_q <= mem.i_mem_rdata;
            end else if (abort && !wren_q) begin
                rdata_q <= 32'h0;
            end
        end
    end

`ifdef LSU_TIMEOUT_EN
    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] tmo_cnt_q;
    logic       err_q;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            tmo_cnt_q <= 8'h0;
            err_q     <= 1'b0;
        end else begin
            if (state_q == IDLE && state_d == REQ) begin
                tmo_cnt_q <= 8'h0;
            end else if (state_q == REQ || state_q == WAIT) begin
                tmo_cnt_q <= tmo_cnt_q + 8'h1;
            end
            err_q <= abort;
        end
    end

    assign timeout   = (state_q == REQ || state_q == WAIT) && (tmo_cnt_q == TimeoutLast);
    assign o_lsu_err = err_q;
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout            = 1'b0;
    assign o_lsu_err          = 1'b0;
`endif

    assign mem.o_mem_req   = (state_q == REQ);
    assign mem.o_mem_we    = (state_q == REQ) & wren_q;
    assign mem.o_mem_addr  = addr_q;
    assign mem.o_mem_wdata = wdata_q;
    assign mem.o_mem_bmask = bmask_q;

    // Stall is raised combinationally so the very first request cycle already holds the pipe.
    assign o_stall_lsu = ((state_q == IDLE) & i_lsu_req) | (state_q == REQ) | (state_q == WAIT);
    assign o_lsu_done  = (state_q == DONE);
    assign o_lsu_rdata = rdata_q;

endmodule
